// File: rtl/pw_pkg.sv
// Shared definitions for the switch/button password lock: sizes, switch FSM states,
// and the one-hot test / digit encoder used on the debounced switch vector.
`timescale 1ns/100ps
package pw_pkg;

    localparam int NUM_SW  = 10;
    localparam int DIGIT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } sw_state_t;

    function automatic logic is_onehot(input logic [NUM_SW-1:0] v);
        return (v != '0) && ((v & (v - NUM_SW'(1))) == '0);
    endfunction

    // Lowest set bit wins, so the loop walks from the top down.
    function automatic logic [DIGIT_W-1:0] encode_lowest(input logic [NUM_SW-1:0] v);
        logic [DIGIT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = DIGIT_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input bit: two-flop synchroniser, stability counter and debounced level register.
`timescale 1ns/100ps
module debounce_cell #(
    parameter int   DEBOUNCE_CYCLES = 3,
    parameter int   CNT_W           = 2,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The level flips on the edge where the count of disagreeing samples would reach the threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= RESET_VAL;
            sync2_reg <= RESET_VAL;
            level_reg <= RESET_VAL;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/pw_input_conditioner.sv
// Input front-end of the password lock: debounces switches and buttons, turns each switch
// press into one digit (or multi-switch error) strobe and each button press into one pulse.
`timescale 1ns/100ps
module pw_input_conditioner
    import pw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SW-1:0]  sw,
    input  logic               btn_start,
    input  logic               btn_end,
    output logic               start_pulse,
    output logic               end_pulse,
    output logic               digit_valid,
    output logic [DIGIT_W-1:0] digit,
    output logic               multi_err,
    output logic               sw_busy
);

    localparam int NUM_IN = NUM_SW + 2;

    logic [NUM_IN-1:0] raw_vec;
    logic [NUM_IN-1:0] db_vec;
    logic [NUM_SW-1:0] sw_db;
    logic              start_db;
    logic              end_db;

    assign raw_vec = {btn_end, btn_start, sw};

    // Buttons are active-low, so their cells idle at 1.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_db
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W),
                .RESET_VAL      ((gi >= NUM_SW) ? 1'b1 : 1'b0)
            ) u_cell (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (raw_vec[gi]),
                .level(db_vec[gi])
            );
        end
    endgenerate

    assign sw_db    = db_vec[NUM_SW-1:0];
    assign start_db = db_vec[NUM_SW];
    assign end_db   = db_vec[NUM_SW+1];

    logic [1:0]         btn_prev_reg;
    logic               start_fall;
    logic               end_fall;
    sw_state_t          state_reg;
    sw_state_t          state_next;
    logic               digit_valid_reg;
    logic               digit_valid_next;
    logic               multi_err_reg;
    logic               multi_err_next;
    logic [DIGIT_W-1:0] digit_reg;
    logic [DIGIT_W-1:0] digit_next;
    logic               start_pulse_reg;
    logic               end_pulse_reg;

    assign start_fall = btn_prev_reg[0] & ~start_db;
    assign end_fall   = btn_prev_reg[1] & ~end_db;

    // A start press re-syncs the FSM to the current switches, so a switch already up never counts.
    always_comb begin
        state_next       = state_reg;
        digit_valid_next = 1'b0;
        multi_err_next   = 1'b0;
        digit_next       = digit_reg;
        if (start_fall) begin
            state_next = (sw_db != '0) ? ST_HELD : ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sw_db != '0) begin
                        state_next = ST_HELD;
                        if (is_onehot(sw_db)) begin
                            digit_valid_next = 1'b1;
                            digit_next       = encode_lowest(sw_db);
                        end else begin
                            multi_err_next = 1'b1;
                        end
                    end
                end
                ST_HELD: begin
                    if (sw_db == '0) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_reg    <= 2'b11;
            state_reg       <= ST_IDLE;
            digit_valid_reg <= 1'b0;
            multi_err_reg   <= 1'b0;
            digit_reg       <= '0;
            start_pulse_reg <= 1'b0;
            end_pulse_reg   <= 1'b0;
        end else begin
            btn_prev_reg    <= {end_db, start_db};
            state_reg       <= state_next;
            digit_valid_reg <= digit_valid_next;
            multi_err_reg   <= multi_err_next;
            digit_reg       <= digit_next;
            start_pulse_reg <= start_fall;
            end_pulse_reg   <= end_fall;
        end
    end

    assign start_pulse = start_pulse_reg;
    assign end_pulse   = end_pulse_reg;
    assign digit_valid = digit_valid_reg;
    assign multi_err   = multi_err_reg;
    assign digit       = digit_reg;
    assign sw_busy     = (state_reg == ST_HELD);

endmodule

// File: tb/tb_pw_input_conditioner.sv
// Bench for pw_input_conditioner: window-based reference model checked every cycle,
// plus directed scenarios with hand-computed counts, latencies and digit values.
`timescale 1ns/100ps
module tb_pw_input_conditioner;

    localparam int D      = 3;
    localparam int NB     = 12;
    localparam logic [NB-1:0] RST_VEC = 12'b1100_0000_0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw = '0;
    logic       btn_start = 1'b1;
    logic       btn_end = 1'b1;
    logic       start_pulse, end_pulse, digit_valid, multi_err, sw_busy;
    logic [3:0] digit;

    always #1 clk = ~clk;

    pw_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .btn_start  (btn_start),
        .btn_end    (btn_end),
        .start_pulse(start_pulse),
        .end_pulse  (end_pulse),
        .digit_valid(digit_valid),
        .digit      (digit),
        .multi_err  (multi_err),
        .sw_busy    (sw_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a level changes once the D samples it is built from all agree and differ from it.
    logic [NB-1:0] m_q[$];
    logic [NB-1:0] m_db   = RST_VEC;
    logic [NB-1:0] m_db_d = RST_VEC;
    logic          exp_dv = 0, exp_me = 0, exp_sp = 0, exp_ep = 0, exp_busy = 0;
    logic [3:0]    exp_digit = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [NB-1:0] old_db, old2_db, new_db, samp, first, dropped;
        logic [9:0]    swv, swv2;
        logic          agree, press, sfall, efall;
        if (!rst_n) begin
            m_q.delete();
            for (int i = 0; i < D + 2; i++) m_q.push_back(RST_VEC);
            m_db = RST_VEC; m_db_d = RST_VEC;
            exp_dv = 0; exp_me = 0; exp_sp = 0; exp_ep = 0; exp_busy = 0; exp_digit = 0;
        end else begin
            old_db  = m_db;
            old2_db = m_db_d;
            m_q.push_back({btn_end, btn_start, sw});
            dropped = m_q.pop_front();
            new_db = old_db;
            for (int b = 0; b < NB; b++) begin
                first = m_q[0];
                agree = 1'b1;
                for (int j = 1; j < D; j++) begin
                    samp = m_q[j];
                    if (samp[b] != first[b]) agree = 1'b0;
                end
                if (agree && first[b] != old_db[b]) new_db[b] = first[b];
            end
            sfall = old2_db[10] && !old_db[10];
            efall = old2_db[11] && !old_db[11];
            swv   = old_db[9:0];
            swv2  = old2_db[9:0];
            press = (swv != 0) && (swv2 == 0) && !sfall;
            exp_dv   = press && ($countones(swv) == 1);
            exp_me   = press && ($countones(swv) > 1);
            if (exp_dv) exp_digit = 4'($clog2(swv));
            exp_sp   = sfall;
            exp_ep   = efall;
            exp_busy = (swv != 0);
            m_db_d = old_db;
            m_db   = new_db;
        end
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int dv_cnt = 0, me_cnt = 0, sp_cnt = 0, ep_cnt = 0, busy_cnt = 0;
    int last_dv = 0, last_me = 0, last_sp = 0, last_ep = 0;

    always @(negedge clk) begin
        chk("digit_valid", int'(digit_valid), int'(exp_dv));
        chk("multi_err",   int'(multi_err),   int'(exp_me));
        chk("start_pulse", int'(start_pulse), int'(exp_sp));
        chk("end_pulse",   int'(end_pulse),   int'(exp_ep));
        chk("sw_busy",     int'(sw_busy),     int'(exp_busy));
        chk("digit",       int'(digit),       int'(exp_digit));
        if (digit_valid === 1'b1) begin dv_cnt++; last_dv = edge_cnt; end
        if (multi_err   === 1'b1) begin me_cnt++; last_me = edge_cnt; end
        if (start_pulse === 1'b1) begin sp_cnt++; last_sp = edge_cnt; end
        if (end_pulse   === 1'b1) begin ep_cnt++; last_ep = edge_cnt; end
        if (sw_busy     === 1'b1) busy_cnt++;
    end

    int dv0, me0, sp0, ep0, busy0, e0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #0.5;
        end
    endtask

    task automatic snap();
        dv0 = dv_cnt; me0 = me_cnt; sp0 = sp_cnt; ep0 = ep_cnt; busy0 = busy_cnt; e0 = edge_cnt;
    endtask

    initial begin
        // 1: reset with idle inputs, then release
        step(5);
        chk("rst_digit", int'(digit), 0);
        chk("rst_busy", int'(sw_busy), 0);
        chk("rst_dv", int'(digit_valid), 0);
        rst_n = 1'b1;
        snap();
        step(5);
        chk("post_rst_strobes", dv_cnt + me_cnt + sp_cnt + ep_cnt - dv0 - me0 - sp0 - ep0, 0);

        // 2: single switch press, 5 cycles
        snap();
        sw = 10'b00_0000_0100;
        step(5);
        sw = '0;
        step(12);
        chk("t2_dv_count", dv_cnt - dv0, 1);
        chk("t2_latency", last_dv - e0, 6);
        chk("t2_digit", int'(digit), 2);
        chk("t2_busy_cycles", busy_cnt - busy0, 5);
        chk("t2_me_count", me_cnt - me0, 0);

        // 3: glitch shorter than the debounce window
        snap();
        sw = 10'b00_1000_0000;
        step(2);
        sw = '0;
        step(10);
        chk("t3_dv_count", dv_cnt - dv0, 0);
        chk("t3_me_count", me_cnt - me0, 0);
        chk("t3_busy_cycles", busy_cnt - busy0, 0);

        // 4: two switches at once
        snap();
        sw = 10'b00_0000_0101;
        step(5);
        sw = '0;
        step(12);
        chk("t4_me_count", me_cnt - me0, 1);
        chk("t4_me_latency", last_me - e0, 6);
        chk("t4_dv_count", dv_cnt - dv0, 0);
        chk("t4_digit_kept", int'(digit), 2);

        // 5: start button held, released, then bouncing
        snap();
        btn_start = 1'b0;
        step(20);
        chk("t5_sp_count", sp_cnt - sp0, 1);
        chk("t5_sp_latency", last_sp - e0, 6);
        btn_start = 1'b1;
        step(12);
        chk("t5_no_release_pulse", sp_cnt - sp0, 1);
        snap();
        for (int i = 0; i < 10; i++) begin
            btn_start = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        btn_start = 1'b1;
        step(10);
        chk("t5_bounce_sp", sp_cnt - sp0, 0);

        // end press coinciding with a switch press: both strobes issued together
        snap();
        btn_end = 1'b0;
        sw = 10'b00_0000_1000;
        step(10);
        chk("t5_ep_count", ep_cnt - ep0, 1);
        chk("t5_dv_with_end", dv_cnt - dv0, 1);
        chk("t5_same_edge", last_ep - last_dv, 0);
        chk("t5_digit", int'(digit), 3);
        btn_end = 1'b1;
        sw = '0;
        step(12);

        // 6: start press coinciding with a switch press suppresses the digit
        snap();
        sw = 10'b00_0010_0000;
        btn_start = 1'b0;
        step(10);
        chk("t6_sp_count", sp_cnt - sp0, 1);
        chk("t6_dv_suppressed", dv_cnt - dv0, 0);
        chk("t6_busy_forced", int'(sw_busy), 1);
        sw = '0;
        btn_start = 1'b1;
        step(12);
        snap();
        sw = 10'b01_0000_0000;
        step(10);
        chk("t6_dv_count", dv_cnt - dv0, 1);
        chk("t6_digit", int'(digit), 8);
        sw = '0;
        step(12);

        // 7: reset during a held press
        sw = 10'b00_0001_0000;
        step(10);
        chk("t7_busy_before", int'(sw_busy), 1);
        rst_n = 1'b0;
        #0.2;
        chk("t7_async_busy", int'(sw_busy), 0);
        chk("t7_async_digit", int'(digit), 0);
        step(1);
        rst_n = 1'b1;
        snap();
        step(10);
        chk("t7_dv_count", dv_cnt - dv0, 1);
        chk("t7_latency", last_dv - e0, 6);
        chk("t7_digit", int'(digit), 4);
        sw = '0;
        step(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
